// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: word type, FSM state
// constants, the default NOP instruction and the PC alignment helper.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_REQUEST = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT    = 3'd2;
    localparam logic [STATE_W-1:0] ST_HOLD    = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd4;

    // addi x0,x0,0
    localparam word_t FETCH_NOP_WORD = 32'h0000_0013;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of control, instruction-memory and decoder signals around the fetch stage.
// imem: imem_req is a one-cycle strobe; the response is the first imem_ack after it.
// decoder: instruction is valid while instr_valid=1 and is taken on instr_consume.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                 start_fetch;
    logic                 redirect_valid;
    word_t                redirect_addr;
    logic                 imem_req;
    word_t                imem_addr;
    logic                 imem_ack;
    word_t                imem_data;
    logic                 instr_valid;
    word_t                instruction;
    word_t                instruction_addr;
    logic                 instr_consume;
    logic                 fetch_busy;
    logic                 fetch_error;
    logic                 misaligned;
    logic [STATE_W-1:0]   dbg_state;

    modport master (
        input  start_fetch, redirect_valid, redirect_addr, imem_ack, imem_data, instr_consume,
        output imem_req, imem_addr, instr_valid, instruction, instruction_addr,
               fetch_busy, fetch_error, misaligned, dbg_state
    );

    modport slave (
        output start_fetch, redirect_valid, redirect_addr, imem_ack, imem_data, instr_consume,
        input  imem_req, imem_addr, instr_valid, instruction, instruction_addr,
               fetch_busy, fetch_error, misaligned, dbg_state
    );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request per fetch, holds the
// returned word for the decoder, and handles writeback redirects and memory timeouts.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t       RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter word_t       NOP_WORD       = FETCH_NOP_WORD
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    word_t              pc_q, pc_d;
    word_t              instr_q, instr_d;
    word_t              iaddr_q, iaddr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               mis_q, mis_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         cnt_inc;
    logic               timed_out;

    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign timed_out = (cnt_q >= TMO_LAST);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        iaddr_d = iaddr_q;
        valid_d = valid_q;
        err_d   = err_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_fetch) state_d = ST_REQUEST;
            end
            // An ack in the REQUEST cycle is handled exactly like one in WAIT.
            ST_REQUEST, ST_WAIT: begin
                if (bus.redirect_valid) begin
                    state_d = bus.imem_ack ? ST_IDLE : ST_DRAIN;
                    cnt_d   = 8'd0;
                end else if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    iaddr_d = pc_q;
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else if (state_q == ST_REQUEST) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HOLD: begin
                if (bus.redirect_valid || bus.instr_consume) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            // A redirect here only moves the PC; the outstanding response is still awaited.
            ST_DRAIN: begin
                if (bus.redirect_valid) begin
                    cnt_d = cnt_inc;
                end else if (bus.imem_ack) begin
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.redirect_valid) begin
            pc_d = word_align(bus.redirect_addr);
            if (bus.redirect_addr[1:0] != 2'b00) mis_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            iaddr_q <= RESET_PC;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            iaddr_q <= iaddr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_req         = (state_q == ST_REQUEST);
    assign bus.imem_addr        = pc_q;
    assign bus.instr_valid      = valid_q;
    assign bus.instruction      = instr_q;
    assign bus.instruction_addr = iaddr_q;
    assign bus.fetch_busy       = (state_q != ST_IDLE);
    assign bus.fetch_error      = err_q;
    assign bus.misaligned       = mis_q;
    assign bus.dbg_state        = state_q;

endmodule
